// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Brief    : EX-stage forwarding selects, ID-stage hazard stall, a countdown
//            scoreboard for one in-flight multicycle (mul/div) op, and a
//            saturating count of stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]          id_src_used_i,
    input  logic [ADDR_W-1:0]           id_dst_i,
    input  logic                        id_regwrite_i,
    input  logic                        id_is_mc_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_i,
    input  logic [ADDR_W-1:0]           ex_dst_i,
    input  logic                        ex_memread_i,
    input  logic [ADDR_W-1:0]           mem_dst_i,
    input  logic                        mem_regwrite_i,
    input  logic [ADDR_W-1:0]           wb_dst_i,
    input  logic                        wb_regwrite_i,
    output logic [2*NUM_SRC-1:0]        fwd_sel_o,
    output logic                        stall_o,
    output logic                        mc_busy_o,
    output logic                        mc_done_o,
    output logic [ADDR_W-1:0]           mc_dst_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    // Countdown width: must hold MC_LAT-2, at least one bit.
    localparam int c_MC_CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [c_MC_CNT_W-1:0] c_MC_LOAD = c_MC_CNT_W'(MC_LAT - 2);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_MC_CNT_W-1:0] r_cnt;
    logic [c_MC_CNT_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0]     r_mc_dst;
    logic [ADDR_W-1:0]     w_mc_dst_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_lu_hit;
    logic w_raw_hit;
    logic w_waw_hit;
    logic w_struct_hit;
    logic w_stall;
    logic w_issue;

    // Per-port forwarding select; MC result outranks MEM, which outranks WB.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        logic [ADDR_W-1:0] w_src;
        assign w_src = ex_src_i[k*ADDR_W +: ADDR_W];
        assign fwd_sel_o[2*k +: 2] =
            (w_src == '0)                              ? 2'b00 :
            ((r_state == c_DONE) && (r_mc_dst == w_src)) ? 2'b11 :
            (mem_regwrite_i && (mem_dst_i == w_src))    ? 2'b10 :
            (wb_regwrite_i && (wb_dst_i == w_src))      ? 2'b01 :
                                                          2'b00;
    end

    // Scan the used ID sources against the load in EX and the pending MC dest.
    always_comb begin
        w_lu_hit  = 1'b0;
        w_raw_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used_i[k] && (id_src_i[k*ADDR_W +: ADDR_W] != '0)) begin
                if (id_src_i[k*ADDR_W +: ADDR_W] == ex_dst_i) begin
                    w_lu_hit = 1'b1;
                end
                if (id_src_i[k*ADDR_W +: ADDR_W] == r_mc_dst) begin
                    w_raw_hit = 1'b1;
                end
            end
        end
    end

    // Hazard terms; RAW releases once the countdown reaches zero so the
    // consumer lands in EX exactly when the MC result is forwardable.
    assign w_waw_hit    = id_regwrite_i && (id_dst_i != '0) && (id_dst_i == r_mc_dst);
    assign w_struct_hit = id_is_mc_i;
    assign w_stall      = id_valid_i &&
                          ((ex_memread_i && w_lu_hit) ||
                           ((r_state == c_BUSY) &&
                            (((r_cnt != '0) && w_raw_hit) || w_waw_hit || w_struct_hit)));
    assign w_issue      = id_valid_i && id_is_mc_i && !w_stall;

    // Scoreboard next-state: count down in BUSY, one-cycle DONE, allow re-issue from DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mc_dst_nxt = r_mc_dst;
        case (r_state)
            c_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - c_MC_CNT_W'(1);
                end
            end
            default: begin
                if (w_issue) begin
                    w_state_nxt  = c_BUSY;
                    w_cnt_nxt    = c_MC_LOAD;
                    w_mc_dst_nxt = id_regwrite_i ? id_dst_i : '0;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_mc_dst <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mc_dst <= w_mc_dst_nxt;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_o     = w_stall;
    assign mc_busy_o   = (r_state == c_BUSY);
    assign mc_done_o   = (r_state == c_DONE);
    assign mc_dst_o    = ((r_state == c_BUSY) || (r_state == c_DONE)) ? r_mc_dst : '0;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_scoreboard
// Brief    : Directed self-checking bench for fwd_hazard_scoreboard
//            (MC_LAT=4), plus a CNT_W=2 instance for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int ADDR_W  = 5;

    logic                      clk_i;
    logic                      rst_i;
    logic                      id_valid_i;
    logic [NUM_SRC*ADDR_W-1:0] id_src_i;
    logic [NUM_SRC-1:0]        id_src_used_i;
    logic [ADDR_W-1:0]         id_dst_i;
    logic                      id_regwrite_i;
    logic                      id_is_mc_i;
    logic [NUM_SRC*ADDR_W-1:0] ex_src_i;
    logic [ADDR_W-1:0]         ex_dst_i;
    logic                      ex_memread_i;
    logic [ADDR_W-1:0]         mem_dst_i;
    logic                      mem_regwrite_i;
    logic [ADDR_W-1:0]         wb_dst_i;
    logic                      wb_regwrite_i;

    logic [2*NUM_SRC-1:0]      fwd_sel_o;
    logic                      stall_o;
    logic                      mc_busy_o;
    logic                      mc_done_o;
    logic [ADDR_W-1:0]         mc_dst_o;
    logic [15:0]               stall_cnt_o;

    logic [2*NUM_SRC-1:0]      s_fwd_sel;
    logic                      s_stall;
    logic                      s_busy;
    logic                      s_done;
    logic [ADDR_W-1:0]         s_dst;
    logic [1:0]                s_stall_cnt;

    int checks = 0;
    int errors = 0;

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .MC_LAT(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_src_i(id_src_i),
        .id_src_used_i(id_src_used_i), .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i),
        .id_is_mc_i(id_is_mc_i), .ex_src_i(ex_src_i), .ex_dst_i(ex_dst_i),
        .ex_memread_i(ex_memread_i), .mem_dst_i(mem_dst_i), .mem_regwrite_i(mem_regwrite_i),
        .wb_dst_i(wb_dst_i), .wb_regwrite_i(wb_regwrite_i), .fwd_sel_o(fwd_sel_o),
        .stall_o(stall_o), .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o),
        .mc_dst_o(mc_dst_o), .stall_cnt_o(stall_cnt_o)
    );

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .MC_LAT(4), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_src_i(id_src_i),
        .id_src_used_i(id_src_used_i), .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i),
        .id_is_mc_i(id_is_mc_i), .ex_src_i(ex_src_i), .ex_dst_i(ex_dst_i),
        .ex_memread_i(ex_memread_i), .mem_dst_i(mem_dst_i), .mem_regwrite_i(mem_regwrite_i),
        .wb_dst_i(wb_dst_i), .wb_regwrite_i(wb_regwrite_i), .fwd_sel_o(s_fwd_sel),
        .stall_o(s_stall), .mc_busy_o(s_busy), .mc_done_o(s_done),
        .mc_dst_o(s_dst), .stall_cnt_o(s_stall_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i     = 1'b0;
        id_src_i       = '0;
        id_src_used_i  = '0;
        id_dst_i       = '0;
        id_regwrite_i  = 1'b0;
        id_is_mc_i     = 1'b0;
        ex_src_i       = '0;
        ex_dst_i       = '0;
        ex_memread_i   = 1'b0;
        mem_dst_i      = '0;
        mem_regwrite_i = 1'b0;
        wb_dst_i       = '0;
        wb_regwrite_i  = 1'b0;
    endtask

    // Put an MC instruction writing dst into ID (caller ticks to issue it).
    task automatic drive_mc(input logic [ADDR_W-1:0] dst);
        idle_inputs();
        id_valid_i    = 1'b1;
        id_is_mc_i    = 1'b1;
        id_regwrite_i = 1'b1;
        id_dst_i      = dst;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b0;
        repeat (2) tick();
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mc_busy_o); end
        checks++; if (mc_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", mc_done_o); end
        checks++; if (mc_dst_o !== 5'd0) begin errors++; $display("FAIL reset_dst: got %0d expected 0", mc_dst_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_fwd_priority();
        idle_inputs();
        mem_dst_i = 5'd5; wb_dst_i = 5'd5; mem_regwrite_i = 1'b1; wb_regwrite_i = 1'b1;
        ex_src_i[0 +: 5] = 5'd5; ex_src_i[5 +: 5] = 5'd5;
        #1;
        checks++; if (fwd_sel_o[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_mem_p0: got %b expected 10", fwd_sel_o[1:0]); end
        checks++; if (fwd_sel_o[3:2] !== 2'b10) begin errors++; $display("FAIL fwd_mem_p1: got %b expected 10", fwd_sel_o[3:2]); end
        mem_regwrite_i = 1'b0;
        #1;
        checks++; if (fwd_sel_o[1:0] !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b expected 01", fwd_sel_o[1:0]); end
        ex_src_i[5 +: 5] = 5'd6;
        #1;
        checks++; if (fwd_sel_o[3:2] !== 2'b00) begin errors++; $display("FAIL fwd_nomatch: got %b expected 00", fwd_sel_o[3:2]); end
        wb_dst_i = 5'd0; mem_dst_i = 5'd0; mem_regwrite_i = 1'b1; ex_src_i[0 +: 5] = 5'd0;
        #1;
        checks++; if (fwd_sel_o[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b expected 00", fwd_sel_o[1:0]); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid_i = 1'b1; ex_memread_i = 1'b1; ex_dst_i = 5'd8;
        id_src_i[5 +: 5] = 5'd8; id_src_used_i = 2'b10;
        id_is_mc_i = 1'b1; id_regwrite_i = 1'b1; id_dst_i = 5'd3;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall_o); end
        tick();
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL lu_issue_suppressed: got %b expected 0", mc_busy_o); end
        id_is_mc_i = 1'b0; ex_memread_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", stall_o); end
        ex_memread_i = 1'b1; id_src_used_i = 2'b01;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_unused: got %b expected 0", stall_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_mc_raw();
        drive_mc(5'd9);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL raw_issue_stall: got %b expected 0", stall_o); end
        tick();
        id_is_mc_i = 1'b0; id_dst_i = 5'd10; id_src_i[0 +: 5] = 5'd9; id_src_used_i = 2'b01;
        #1;
        checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL raw_busy0: got %b expected 1", mc_busy_o); end
        checks++; if (mc_dst_o !== 5'd9) begin errors++; $display("FAIL raw_dst: got %0d expected 9", mc_dst_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall_c0: got %b expected 1", stall_o); end
        tick();
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall_c1: got %b expected 1", stall_o); end
        tick();
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", stall_o); end
        checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL raw_busy2: got %b expected 1", mc_busy_o); end
        checks++; if (mc_done_o !== 1'b0) begin errors++; $display("FAIL raw_early_done: got %b expected 0", mc_done_o); end
        tick();
        id_valid_i = 1'b0; ex_src_i[0 +: 5] = 5'd9; mem_regwrite_i = 1'b1; mem_dst_i = 5'd9;
        #1;
        checks++; if (mc_done_o !== 1'b1) begin errors++; $display("FAIL raw_done: got %b expected 1", mc_done_o); end
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL raw_done_busy: got %b expected 0", mc_busy_o); end
        checks++; if (mc_dst_o !== 5'd9) begin errors++; $display("FAIL raw_done_dst: got %0d expected 9", mc_dst_o); end
        checks++; if (fwd_sel_o[1:0] !== 2'b11) begin errors++; $display("FAIL raw_fwd_mc: got %b expected 11", fwd_sel_o[1:0]); end
        tick();
        checks++; if (mc_done_o !== 1'b0) begin errors++; $display("FAIL raw_done_once: got %b expected 0", mc_done_o); end
        checks++; if (mc_dst_o !== 5'd0) begin errors++; $display("FAIL raw_idle_dst: got %0d expected 0", mc_dst_o); end
        checks++; if (fwd_sel_o[1:0] !== 2'b10) begin errors++; $display("FAIL raw_fwd_after: got %b expected 10", fwd_sel_o[1:0]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        drive_mc(5'd9);
        tick();
        id_dst_i = 5'd12;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_struct: got %b expected 1", stall_o); end
        tick();
        tick();
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_struct_cnt0: got %b expected 1", stall_o); end
        tick();
        checks++; if (mc_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", mc_done_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b expected 0", stall_o); end
        tick();
        checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL b2b_rebusy: got %b expected 1", mc_busy_o); end
        checks++; if (mc_dst_o !== 5'd12) begin errors++; $display("FAIL b2b_newdst: got %0d expected 12", mc_dst_o); end
        idle_inputs();
        tick();
        tick();
        tick();
        checks++; if (mc_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", mc_done_o); end
        checks++; if (mc_dst_o !== 5'd12) begin errors++; $display("FAIL b2b_done2_dst: got %0d expected 12", mc_dst_o); end
        tick();
        checks++; if (mc_busy_o !== 1'b0 || mc_done_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", mc_busy_o, mc_done_o); end
    endtask

    task automatic test_waw_r0();
        drive_mc(5'd9);
        tick();
        id_is_mc_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", stall_o); end
        tick();
        tick();
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall_cnt0: got %b expected 1", stall_o); end
        id_regwrite_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL waw_norw: got %b expected 0", stall_o); end
        idle_inputs();
        tick();
        tick();
        drive_mc(5'd0);
        tick();
        id_is_mc_i = 1'b0; id_src_used_i = 2'b01;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL r0_nostall: got %b expected 0", stall_o); end
        checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL r0_busy: got %b expected 1", mc_busy_o); end
        checks++; if (mc_dst_o !== 5'd0) begin errors++; $display("FAIL r0_dst: got %0d expected 0", mc_dst_o); end
        idle_inputs();
        tick();
        tick();
        tick();
        checks++; if (mc_done_o !== 1'b1) begin errors++; $display("FAIL r0_done: got %b expected 1", mc_done_o); end
        checks++; if (fwd_sel_o[1:0] !== 2'b00) begin errors++; $display("FAIL r0_nofwd: got %b expected 00", fwd_sel_o[1:0]); end
        ex_src_i[0 +: 5] = 5'd9;
        #1;
        checks++; if (fwd_sel_o[1:0] !== 2'b00) begin errors++; $display("FAIL r0_stale_dst: got %b expected 00", fwd_sel_o[1:0]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive_mc(5'd9);
        tick();
        id_is_mc_i = 1'b0; id_dst_i = 5'd10; id_src_i[0 +: 5] = 5'd9; id_src_used_i = 2'b01;
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", mc_busy_o); end
        checks++; if (mc_dst_o !== 5'd0) begin errors++; $display("FAIL rst_mid_dst: got %0d expected 0", mc_dst_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cnt_o); end
        rst_i = 1'b1;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (mc_done_o !== 1'b0) begin errors++; $display("FAIL rst_no_done: cycle %0d got %b expected 0", i, mc_done_o); end
        end
    endtask

    task automatic test_counter();
        idle_inputs();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        checks++; if (s_stall_cnt !== 2'd0) begin errors++; $display("FAIL cnt_reset: got %0d expected 0", s_stall_cnt); end
        drive_mc(5'd9);
        tick();
        id_is_mc_i = 1'b0; id_dst_i = 5'd10; id_src_i[0 +: 5] = 5'd9; id_src_used_i = 2'b01;
        ex_memread_i = 1'b1; ex_dst_i = 5'd9;
        tick();
        checks++; if (stall_cnt_o !== 16'd1) begin errors++; $display("FAIL cnt_combined: got %0d expected 1", stall_cnt_o); end
        checks++; if (s_stall_cnt !== 2'd1) begin errors++; $display("FAIL cnt_sat1: got %0d expected 1", s_stall_cnt); end
        tick();
        tick();
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat3: got %0d expected 3", s_stall_cnt); end
        tick();
        tick();
        checks++; if (stall_cnt_o !== 16'd5) begin errors++; $display("FAIL cnt_main5: got %0d expected 5", stall_cnt_o); end
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat_hold: got %0d expected 3", s_stall_cnt); end
        idle_inputs();
        tick();
        checks++; if (stall_cnt_o !== 16'd5) begin errors++; $display("FAIL cnt_hold: got %0d expected 5", stall_cnt_o); end
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_mc_raw();
        test_back_to_back();
        test_waw_r0();
        test_reset_mid_busy();
        test_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
